// File: rtl/morningjava_pkg.sv
`default_nettype none
// ============================================================================
// Package  : morningjava_pkg
// Brief    : Shared commands, sizes and state types for the pattern sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package morningjava_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int DATA_W    = 4;

  typedef enum logic [3:0] {
    CMD_PROJ   = 4'h0,
    CMD_TAP    = 4'h1,
    CMD_SLOT0  = 4'h2,
    CMD_SLOT1  = 4'h3,
    CMD_SLOT2  = 4'h4,
    CMD_SLOT3  = 4'h5,
    CMD_SLOT4  = 4'h6,
    CMD_SLOT5  = 4'h7,
    CMD_SLOT6  = 4'h8,
    CMD_SLOT7  = 4'h9,
    CMD_PERIOD = 4'hA,
    CMD_RUN    = 4'hB
  } cmd_e;

  typedef enum logic {
    STOPPED = 1'b0,
    PLAYING = 1'b1
  } play_state_e;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Slot commands occupy 0x2..0x9, so the slot number is the command minus 2.
  function automatic logic [2:0] slot_idx(input logic [3:0] cmd);
    return 3'(cmd - 4'h2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/morningjava_seq_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : One-sample-per-bit serial receiver, LSB first, idle-high line.
// Config   : MORNINGJAVA_PARITY_EN adds an odd-parity bit before the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import morningjava_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sdi,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  rx_state_e  r_state;
  rx_state_e  w_state_nxt;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_valid;
  logic       r_ferr;
  logic       w_shift_en;
  logic       w_stop;
  logic       w_par_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!i_sdi) w_state_nxt = RX_DATA;
      end
      RX_DATA: begin
        w_shift_en = 1'b1;
        if (r_cnt == 3'd7) begin
`ifdef MORNINGJAVA_PARITY_EN
          w_state_nxt = RX_PARITY;
`else
          w_state_nxt = RX_STOP;
`endif
        end
      end
      RX_PARITY: w_state_nxt = RX_STOP;
      RX_STOP: begin
        w_stop      = 1'b1;
        w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_state == RX_IDLE) r_cnt <= 3'd0;
      else if (w_shift_en)    r_cnt <= r_cnt + 3'd1;
      if (w_shift_en) r_shift <= {i_sdi, r_shift[7:1]};
      if (w_stop) begin
        if (i_sdi && w_par_ok) r_valid <= 1'b1;
        else                   r_ferr  <= 1'b1;
      end
    end
  end

`ifdef MORNINGJAVA_PARITY_EN
  logic r_par_ok;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_par_ok <= 1'b0;
    else if (r_state == RX_PARITY) r_par_ok <= ^{r_shift, i_sdi};
  end
  assign w_par_ok = r_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  assign o_byte       = r_shift;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: rtl/morningjava_seq.sv
`default_nettype none
// ============================================================================
// Module   : morningjava_seq
// Brief    : Serial-commanded 8-slot pattern sequencer driving a 4-bit DAC.
// Config   : MORNINGJAVA_PARITY_EN selects 11-bit odd-parity command frames.
// Revision : 1.0 - initial release
// ============================================================================
module morningjava_seq
  import morningjava_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdi,
  output logic              sck,
  output logic [DATA_W-1:0] dac,
  output logic [DATA_W-1:0] proj_sel,
  output logic [DATA_W-1:0] tap_sel,
  output logic              playing,
  output logic              frame_err
);

  logic [7:0]        w_rx_byte;
  logic              w_rx_valid;
  logic              w_rx_ferr;
  logic [3:0]        w_cmd;
  logic [3:0]        w_arg;
  logic              w_is_proj;
  logic              w_is_tap;
  logic              w_is_slot;
  logic              w_is_period;
  logic              w_is_run;
  logic [2:0]        w_wr_idx;

  play_state_e       r_state;
  play_state_e       w_state_nxt;
  logic              w_start;
  logic              w_advance;
  logic              r_run;
  logic [DATA_W-1:0] r_dac;
  logic [DATA_W-1:0] r_proj;
  logic [DATA_W-1:0] r_tap;
  logic [DATA_W-1:0] r_period;
  logic [DATA_W-1:0] r_div;
  logic [2:0]        r_step;
  logic [2:0]        w_eff_step;
  logic [2:0]        w_step_adv;
  logic [DATA_W-1:0] w_slot_val;
  logic [DATA_W-1:0] r_slot [NUM_SLOTS];

  uart_rx u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sdi        (sdi),
    .o_byte       (w_rx_byte),
    .o_byte_valid (w_rx_valid),
    .o_frame_err  (w_rx_ferr)
  );

  assign w_cmd       = w_rx_byte[7:4];
  assign w_arg       = w_rx_byte[3:0];
  assign w_is_proj   = w_rx_valid && (w_cmd == CMD_PROJ);
  assign w_is_tap    = w_rx_valid && (w_cmd == CMD_TAP);
  assign w_is_slot   = w_rx_valid && (w_cmd >= CMD_SLOT0) && (w_cmd <= CMD_SLOT7);
  assign w_is_period = w_rx_valid && (w_cmd == CMD_PERIOD);
  assign w_is_run    = w_rx_valid && (w_cmd == CMD_RUN);
  assign w_wr_idx    = slot_idx(w_cmd);

  // A step beyond a freshly shrunk tap restarts the pattern from slot 0.
  assign w_eff_step = (r_step > r_tap[2:0]) ? 3'd0 : r_step;
  assign w_step_adv = (w_eff_step >= r_tap[2:0]) ? 3'd0 : w_eff_step + 3'd1;
  assign w_slot_val = (w_is_slot && (w_wr_idx == w_eff_step)) ? w_arg : r_slot[w_eff_step];

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      STOPPED: begin
        if (w_is_run && w_arg[0]) begin
          w_state_nxt = PLAYING;
          w_start     = 1'b1;
        end
      end
      PLAYING: begin
        if (w_is_proj || (w_is_run && !w_arg[0])) w_state_nxt = STOPPED;
      end
      default: w_state_nxt = STOPPED;
    endcase
    w_advance = (r_state == PLAYING) && (w_state_nxt == PLAYING) &&
                (r_div == r_period) && !w_is_period;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= STOPPED;
      r_run    <= 1'b0;
      r_dac    <= '0;
      r_proj   <= '0;
      r_tap    <= '0;
      r_period <= '0;
      r_div    <= '0;
      r_step   <= 3'd0;
      for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_is_proj)   r_proj           <= w_arg;
      if (w_is_tap)    r_tap            <= w_arg;
      if (w_is_slot)   r_slot[w_wr_idx] <= w_arg;
      if (w_is_period) r_period         <= w_arg;

      if (w_is_proj) begin
        r_step <= 3'd0;
        r_div  <= '0;
        r_dac  <= '0;
      end else if (w_start) begin
        r_step <= 3'd0;
        r_div  <= '0;
      end else if (r_state == PLAYING) begin
        if (w_is_period || w_advance) r_div <= '0;
        else                          r_div <= r_div + 4'd1;
        if (w_advance) begin
          r_dac  <= w_slot_val;
          r_step <= w_step_adv;
        end
      end
    end
  end

  assign sck       = clk & r_run;
  assign dac       = r_dac;
  assign proj_sel  = r_proj;
  assign tap_sel   = r_tap;
  assign playing   = (r_state == PLAYING);
  assign frame_err = w_rx_ferr;

endmodule
`default_nettype wire

// File: tb/tb_morningjava_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_morningjava_seq
// Brief    : Scoreboard bench: expected output events are queued by stimulus
//            and popped by a monitor whenever the DUT outputs change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morningjava_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sdi   = 1'b1;
  logic       sck;
  logic [3:0] dac;
  logic [3:0] proj_sel;
  logic [3:0] tap_sel;
  logic       playing;
  logic       frame_err;

  morningjava_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sdi       (sdi),
    .sck       (sck),
    .dac       (dac),
    .proj_sel  (proj_sel),
    .tap_sel   (tap_sel),
    .playing   (playing),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

`ifdef MORNINGJAVA_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  typedef struct {
    string      name;
    logic [3:0] proj;
    logic [3:0] tap;
    logic       play;
    logic [3:0] dac;
    logic       ferr;
    int         gap;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_en  = 1'b0;
  logic [3:0] seq_a [7] = '{4'h5, 4'hA, 4'h7, 4'h1, 4'h5, 4'hA, 4'h7};

  task automatic expect_ev(input string name, input logic [3:0] p, input logic [3:0] t,
                           input logic pl, input logic [3:0] d, input logic fe, input int gap);
    exp_t e;
    e.name = name; e.proj = p; e.tap = t; e.play = pl; e.dac = d; e.ferr = fe; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) sdi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) sdi = b[i];
    end
`ifdef MORNINGJAVA_PARITY_EN
    @(negedge clk) sdi = ~^b;
`endif
    @(negedge clk) sdi = stop_bit;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) sdi = 1'b1;
  endtask

  // Monitor: any change of the steady outputs, or a frame_err pulse, is an event.
  initial begin
    logic [12:0] prev;
    logic [12:0] snap;
    int          cyc;
    int          last;
    exp_t        e;
    prev = '0;
    cyc  = 0;
    last = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cyc++;
      snap = {proj_sel, tap_sel, playing, dac};
      if (snap !== prev || frame_err !== 1'b0) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got proj=%h tap=%h playing=%b dac=%h frame_err=%b, required no change",
                   proj_sel, tap_sel, playing, dac, frame_err);
        end else begin
          e = q.pop_front();
          if (snap !== {e.proj, e.tap, e.play, e.dac} || frame_err !== e.ferr ||
              (e.gap != 0 && (cyc - last) != e.gap)) begin
            n_fail++;
            $display("FAIL %s: got proj=%h tap=%h playing=%b dac=%h frame_err=%b gap=%0d, required proj=%h tap=%h playing=%b dac=%h frame_err=%b gap=%0d",
                     e.name, proj_sel, tap_sel, playing, dac, frame_err, cyc - last,
                     e.proj, e.tap, e.play, e.dac, e.ferr, e.gap);
          end
        end
        last = cyc;
        prev = snap;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {2'b00, dac, proj_sel, tap_sel, playing, frame_err}, 16'h0000);
    check("reset_sck_low", {15'd0, sck}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("sck_after_second_rise", {15'd0, sck}, 16'h0001);
    @(negedge clk);
    check("release_outputs", {2'b00, dac, proj_sel, tap_sel, playing, frame_err}, 16'h0000);
    mon_en = 1'b1;

    expect_ev("proj_1",          4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 0);
    send_byte(8'h01, 1'b1);
    expect_ev("tap_3",           4'h1, 4'h3, 1'b0, 4'h0, 1'b0, 0);
    send_byte(8'h13, 1'b1);
    expect_ev("frame_err_pulse", 4'h1, 4'h3, 1'b0, 4'h0, 1'b1, 0);
    send_byte(8'h55, 1'b0);
    expect_ev("tap_2_after_err", 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 0);
    send_byte(8'h12, 1'b1);
    expect_ev("tap_3_restore",   4'h1, 4'h3, 1'b0, 4'h0, 1'b0, 0);
    send_byte(8'h13, 1'b1);
    send_byte(8'h25, 1'b1);
    send_byte(8'h3A, 1'b1);
    send_byte(8'h47, 1'b1);
    send_byte(8'h51, 1'b1);
    send_byte(8'hA1, 1'b1);

    // Step interval 2: playing rises, then a new slot value every 2 cycles.
    expect_ev("play_start", 4'h1, 4'h3, 1'b1, 4'h0, 1'b0, 0);
    for (int i = 0; i < 7; i++)
      expect_ev($sformatf("play_step%0d", i), 4'h1, 4'h3, 1'b1, seq_a[i], 1'b0, 2);
    expect_ev("tap_shrink",    4'h1, 4'h1, 1'b1, 4'h7, 1'b0, 1);
    expect_ev("wrap_to_slot0", 4'h1, 4'h1, 1'b1, 4'h5, 1'b0, 1);
    expect_ev("tap1_step_a",   4'h1, 4'h1, 1'b1, 4'hA, 1'b0, 2);
    expect_ev("tap1_step_b",   4'h1, 4'h1, 1'b1, 4'h5, 1'b0, 2);
    expect_ev("tap1_step_c",   4'h1, 4'h1, 1'b1, 4'hA, 1'b0, 2);
    expect_ev("tap1_step_d",   4'h1, 4'h1, 1'b1, 4'h5, 1'b0, 2);
    expect_ev("stop_cmd0",     4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 0);
    send_byte(8'hB1, 1'b1);
    idle(15 - FL);
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(6);

    // Reset in the middle of a 0x1F frame, after four data bits.
    expect_ev("reset_midframe", 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 0);
    @(negedge clk) sdi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) sdi = 1'b1;
    end
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 check("sck_low_midframe_reset", {15'd0, sck}, 16'h0000);
    @(negedge clk) begin
      rst_n = 1'b1;
      sdi   = 1'b1;
    end
    idle(20);

    expect_ev("recover_tap4", 4'h0, 4'h4, 1'b0, 4'h0, 1'b0, 0);
    send_byte(8'h14, 1'b1);
    idle(6);

    check("scoreboard_drained", 16'(q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
